bsg_realram_banked_1rw1r: RTL and testbench
===========================================

// Module: bsg_realram_banked_1rw1r
// PURPOSE
//  Parametrised successor of the single 8x1024 sky130 SRAM macro wrapper: tiles
//  sky130_sram_1kbyte_1rw1r_8x1024_8 macros in width (byte lanes) and depth (banks)
//  to form one BITS x 2^ADDR_WIDTH memory. Port A is read/write, port B is read-only.
//  Both ports use a valid/ready request handshake and a valid-only response.
//  After reset the block zero-fills the array before accepting requests.
//  It sits between core-side memory controllers and the hard macros.
// PARAMETERS
//  BITS        32  data width; multiple of 8; BITS/8 macros per bank (one per byte lane)
//  ADDR_WIDTH  11  word address width; >=10; BANKS = 2**(ADDR_WIDTH-10), 1024 words per bank
// PORTS
//  clk         in   1           clock; drives both macro ports
//  reset       in   1           synchronous, active-high reset
//  init_done_o out  1           high once the zero-fill is complete
//  a_v_i       in   1           port A request valid
//  a_ready_o   out  1           port A can accept a request
//  a_w_i       in   1           1 = write, 0 = read
//  a_addr_i    in   ADDR_WIDTH  port A word address; MSBs select the bank
//  a_data_i    in   BITS        write data
//  a_mask_i    in   BITS/8      byte write enable; 1 = write that lane
//  a_v_o       out  1           port A read data valid (one-cycle pulse)
//  a_data_o    out  BITS        port A read data
//  b_v_i       in   1           port B read request valid
//  b_ready_o   out  1           port B can accept a request
//  b_addr_i    in   ADDR_WIDTH  port B word address
//  b_v_o       out  1           port B read data valid (one-cycle pulse)
//  b_data_o    out  BITS        port B read data
// BEHAVIOUR
//  - Reset values: init_done_o=0, a_ready_o=0, b_ready_o=0, a_v_o=0, b_v_o=0,
//    a_data_o=0, b_data_o=0.
//  - FSM states and transitions:
//      INIT  -> on reset. A 10-bit counter runs 0..1023. Each cycle, port 0 of every
//               macro in every bank writes 0 (all lanes). All macros clear in parallel.
//      READY -> entered when the counter reaches 1023 (1024 cycles after reset falls).
//               init_done_o=1.
//  - reset asserted in any state (including mid-INIT) returns to INIT and clears the counter.
//  - Ready rules:
//      a_ready_o = (state==READY).
//      b_ready_o = (state==READY) & ~(a_v_i & a_w_i & a_addr_i==b_addr_i).
//      A same-address write on A stalls B for that cycle. The write always wins.
//  - A request is accepted when valid & ready.
//  - Accepted A write: port 0 of the addressed bank writes the enabled lanes only.
//    Other banks are not selected (csb high). No response is produced.
//  - Accepted read (A or B): bank index is registered with the request.
//    Response appears LAT cycles after acceptance: v_o=1 for exactly one cycle;
//    data_o = dout of the registered bank.
//  - Back-to-back reads sustain one per cycle per port.
//  - data_o holds its last value while v_o=0.
//  - Both ports may read the same address in the same cycle; both return identical data.
//  - Reads to an address while A writes a different address return old data.
//  - Macro chip selects and write enables are active-low: csb=~accept, web=~(accept&a_w_i).
//  - Idle macros keep csb=1.
//  - The bank index is ADDR_WIDTH-10 bits; for ADDR_WIDTH==10 there is no bank mux.
// CONFIGURATION
//  BSG_REALRAM_OUTPUT_REG_EN
//    defined:   adds one register stage on a_data_o/a_v_o and b_data_o/b_v_o; LAT=2.
//    undefined: response is driven from the macro read-data cycle; LAT=1.
//  Ready and collision rules are identical in both builds.
// TESTING (BITS=32, ADDR_WIDTH=11, run with and without the macro)
//  1. Reset for 3 cycles, release
//     -> init_done_o=0 and both ready_o=0 for 1024 cycles, then 1.
//     -> A read of 0x000 and 0x7FF both return 0x00000000.
//  2. A writes 0x405=0xDEADBEEF (mask 4'hF), then A reads 0x405
//     -> a_v_o pulses LAT cycles after the read with 0xDEADBEEF.
//     -> B read of 0x005 (bank 0) returns 0.
//  3. A writes 0x010=0x11223344 (mask 4'hF), then A writes 0x010=0xAABBCCDD (mask 4'b0101)
//     -> a read returns 0x11BB33DD.
//  4. Same cycle: A writes 0x020, B reads 0x020
//     -> b_ready_o=0 that cycle. B is accepted next cycle and returns the new data.
//     -> Same cycle A write 0x020, B read 0x021 -> both accepted.
//  5. Stream 8 consecutive reads on both ports, addresses alternating between banks
//     -> 8 consecutive v_o pulses per port, data in order, no bubbles.
//  6. Assert reset at counter=500 in INIT
//     -> the counter restarts; init_done_o rises 1024 cycles after reset falls.

Source files
------------

// File: rtl/bsg_realram_banked_1rw1r.sv
// bsg_realram_banked_1rw1r
//   BITS x 2^ADDR_WIDTH memory tiled from 8x1024 1rw1r sky130 SRAM macros:
//   BITS/8 byte-lane macros per bank, 2^(ADDR_WIDTH-10) banks.
//   Port A (macro port 0) reads/writes, port B (macro port 1) only reads.
//   After reset the whole array is zero-filled before requests are accepted.
//   Optional build macro BSG_REALRAM_OUTPUT_REG_EN registers the read
//   responses (latency 2 instead of 1).
//   A behavioural model of the macro is included below.

// Behavioural model of sky130_sram_1kbyte_1rw1r_8x1024_8 (active-low selects,
// registered read data that holds while the port is idle).
module sky130_sram_1kbyte_1rw1r_8x1024_8 (
    input  logic       clk0,
    input  logic       csb0,
    input  logic       web0,
    input  logic [0:0] wmask0,
    input  logic [9:0] addr0,
    input  logic [7:0] din0,
    output logic [7:0] dout0,
    input  logic       clk1,
    input  logic       csb1,
    input  logic [9:0] addr1,
    output logic [7:0] dout1
);
    logic [7:0] mem [1024];

    // Port 0: masked write or read of the selected word
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                if (wmask0[0]) mem[addr0] <= din0;
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    // Port 1: read only
    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end
endmodule

module bsg_realram_banked_1rw1r #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_done_o,
    input  logic                  a_v_i,
    output logic                  a_ready_o,
    input  logic                  a_w_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [BITS-1:0]       a_data_i,
    input  logic [BITS/8-1:0]     a_mask_i,
    output logic                  a_v_o,
    output logic [BITS-1:0]       a_data_o,
    input  logic                  b_v_i,
    output logic                  b_ready_o,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic                  b_v_o,
    output logic [BITS-1:0]       b_data_o
);
    localparam int LANES     = BITS / 8;
    localparam int BANK_BITS = ADDR_WIDTH - 10;
    localparam int BANKS     = 1 << BANK_BITS;
    localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic {INIT, READY} state_e;

    state_e                      state_q, state_d;
    logic [9:0]                  cnt_q, cnt_d;
    logic                        init_wr;
    logic                        a_accept, b_accept;
    logic [BW-1:0]               a_bank, b_bank;
    logic [BW-1:0]               a_bank_q, b_bank_q;
    logic                        a_rd_q, b_rd_q;
    logic [BANKS-1:0]            csb0, web0, csb1;
    logic [9:0]                  addr0;
    logic [BITS-1:0]             din0;
    logic [LANES-1:0]            wmask;
    logic [BANKS-1:0][BITS-1:0]  dout0, dout1;
    logic [BITS-1:0]             a_rd_data, b_rd_data;

    // State and zero-fill counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, fill counter and handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_wr     = 1'b0;
        init_done_o = 1'b0;
        a_ready_o   = 1'b0;
        b_ready_o   = 1'b0;
        case (state_q)
            INIT: begin
                init_wr = 1'b1;
                cnt_d   = cnt_q + 10'd1;
                if (cnt_q == 10'd1023) state_d = READY;
            end
            READY: begin
                init_done_o = 1'b1;
                a_ready_o   = 1'b1;
                // a same-address write on A always wins over a B read
                b_ready_o   = ~(a_v_i & a_w_i & (a_addr_i == b_addr_i));
            end
            default: state_d = INIT;
        endcase
    end

    assign a_accept = a_v_i & a_ready_o;
    assign b_accept = b_v_i & b_ready_o;

    if (BANK_BITS > 0) begin : g_bank_idx
        assign a_bank = a_addr_i[ADDR_WIDTH-1:10];
        assign b_bank = b_addr_i[ADDR_WIDTH-1:10];
    end else begin : g_no_bank_idx
        assign a_bank = '0;
        assign b_bank = '0;
    end

    // Port-0 shared address/data: fill counter during INIT, port A otherwise
    assign addr0 = init_wr ? cnt_q : a_addr_i[9:0];
    assign din0  = init_wr ? '0 : a_data_i;
    assign wmask = init_wr ? '1 : a_mask_i;

    // Per-bank active-low chip selects and write enables
    always_comb begin
        csb0 = '1;
        web0 = '1;
        csb1 = '1;
        for (int unsigned k = 0; k < BANKS; k++) begin
            if (init_wr) begin
                csb0[k] = 1'b0;
                web0[k] = 1'b0;
            end else begin
                if (a_accept && a_bank == BW'(k)) begin
                    csb0[k] = 1'b0;
                    web0[k] = ~a_w_i;
                end
                if (b_accept && b_bank == BW'(k)) csb1[k] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            sky130_sram_1kbyte_1rw1r_8x1024_8 macro (
                .clk0   (clk),
                .csb0   (csb0[g]),
                .web0   (web0[g]),
                .wmask0 (wmask[l]),
                .addr0  (addr0),
                .din0   (din0[8*l +: 8]),
                .dout0  (dout0[g][8*l +: 8]),
                .clk1   (clk),
                .csb1   (csb1[g]),
                .addr1  (b_addr_i[9:0]),
                .dout1  (dout1[g][8*l +: 8])
            );
        end
    end

    // Read-request tracking: valid flag and bank of the accepted read
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rd_q   <= 1'b0;
            b_rd_q   <= 1'b0;
            a_bank_q <= '0;
            b_bank_q <= '0;
        end else begin
            a_rd_q <= a_accept & ~a_w_i;
            b_rd_q <= b_accept;
            if (a_accept) a_bank_q <= a_bank;
            if (b_accept) b_bank_q <= b_bank;
        end
    end

    if (BANK_BITS > 0) begin : g_bank_mux
        assign a_rd_data = dout0[a_bank_q];
        assign b_rd_data = dout1[b_bank_q];
    end else begin : g_single_bank
        assign a_rd_data = dout0[0];
        assign b_rd_data = dout1[0];
    end

`ifdef BSG_REALRAM_OUTPUT_REG_EN
    // Registered response stage; data only updates on a returning read
    always_ff @(posedge clk) begin
        if (reset) begin
            a_v_o    <= 1'b0;
            b_v_o    <= 1'b0;
            a_data_o <= '0;
            b_data_o <= '0;
        end else begin
            a_v_o <= a_rd_q;
            b_v_o <= b_rd_q;
            if (a_rd_q) a_data_o <= a_rd_data;
            if (b_rd_q) b_data_o <= b_rd_data;
        end
    end
`else
    logic [BITS-1:0] a_hold_q, b_hold_q;

    // Capture the last response so data_o holds while no read returns
    always_ff @(posedge clk) begin
        if (reset) begin
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            if (a_rd_q) a_hold_q <= a_rd_data;
            if (b_rd_q) b_hold_q <= b_rd_data;
        end
    end

    assign a_v_o    = a_rd_q;
    assign b_v_o    = b_rd_q;
    assign a_data_o = a_rd_q ? a_rd_data : a_hold_q;
    assign b_data_o = b_rd_q ? b_rd_data : b_hold_q;
`endif

endmodule

// File: tb/tb_bsg_realram_banked_1rw1r.sv
// Testbench for bsg_realram_banked_1rw1r (BITS=32, ADDR_WIDTH=11).
module tb_bsg_realram_banked_1rw1r;
    localparam int BITS = 32;
    localparam int AW   = 11;
`ifdef BSG_REALRAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_done_o;
    logic          a_v_i = 1'b0, a_w_i = 1'b0, b_v_i = 1'b0;
    logic          a_ready_o, b_ready_o, a_v_o, b_v_o;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [31:0]   a_data_i = '0;
    logic [3:0]    a_mask_i = '0;
    logic [31:0]   a_data_o, b_data_o;

    always #5 clk = ~clk;

    bsg_realram_banked_1rw1r #(.BITS(BITS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .init_done_o(init_done_o),
        .a_v_i(a_v_i), .a_ready_o(a_ready_o), .a_w_i(a_w_i), .a_addr_i(a_addr_i),
        .a_data_i(a_data_i), .a_mask_i(a_mask_i), .a_v_o(a_v_o), .a_data_o(a_data_o),
        .b_v_i(b_v_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i),
        .b_v_o(b_v_o), .b_data_o(b_data_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [2048];
    typedef struct { logic [31:0] data; int due; } resp_t;
    resp_t qa[$], qb[$];
    logic [31:0] last_a = '0, last_b = '0;

    typedef struct {
        logic av; logic aw; logic [10:0] aa; logic [31:0] ad; logic [3:0] am;
        logic bv; logic [10:0] ba; logic ebr; logic [31:0] ea; logic [31:0] eb;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        if (qa.size() > 0 && qa[0].due == cyc) begin
            check("a_v", a_v_o, 1);
            check("a_data", a_data_o, qa[0].data);
            last_a = qa[0].data;
            qa.delete(0);
        end else begin
            check("a_v_idle", a_v_o, 0);
            check("a_data_hold", a_data_o, last_a);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            check("b_v", b_v_o, 1);
            check("b_data", b_data_o, qb[0].data);
            last_b = qb[0].data;
            qb.delete(0);
        end else begin
            check("b_v_idle", b_v_o, 0);
            check("b_data_hold", b_data_o, last_b);
        end
    endtask

    // One READY-state cycle: drive at negedge, check handshakes, update the model,
    // then check responses at the following negedge.
    task automatic step(input logic av, input logic aw, input logic [10:0] aa,
                        input logic [31:0] ad, input logic [3:0] am,
                        input logic bv, input logic [10:0] ba,
                        input logic use_exp, input logic [31:0] ea,
                        input logic [31:0] eb, input logic ebr);
        logic        exp_br;
        logic [31:0] ra, rb;
        a_v_i = av; a_w_i = aw; a_addr_i = aa; a_data_i = ad; a_mask_i = am;
        b_v_i = bv; b_addr_i = ba;
        #1;
        exp_br = use_exp ? ebr : !(av && aw && aa == ba);
        check("a_ready", a_ready_o, 1);
        check("b_ready", b_ready_o, exp_br);
        ra = use_exp ? ea : ref_mem[aa];
        rb = use_exp ? eb : ref_mem[ba];
        @(posedge clk);
        cyc++;
        if (av && !aw) qa.push_back('{ra, cyc + LAT - 1});
        if (bv && exp_br) qb.push_back('{rb, cyc + LAT - 1});
        if (av && aw)
            for (int l = 0; l < 4; l++)
                if (am[l]) ref_mem[aa][8*l +: 8] = ad[8*l +: 8];
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, '0, 0, '0, '0, 1'b1);
    endtask

    // Hold reset for n cycles (from a negedge), check reset values, release.
    task automatic do_reset(input int n);
        reset = 1'b1;
        a_v_i = 0; a_w_i = 0; b_v_i = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", init_done_o, 0);
        check("rst_a_ready", a_ready_o, 0);
        check("rst_b_ready", b_ready_o, 0);
        check("rst_a_v", a_v_o, 0);
        check("rst_b_v", b_v_o, 0);
        check("rst_a_data", a_data_o, 0);
        check("rst_b_data", b_data_o, 0);
        reset = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        last_a = '0; last_b = '0;
    endtask

    // Count cycles from reset release until init_done_o rises (bounded).
    task automatic wait_init(input string name);
        int n, early;
        n = 0; early = 0;
        while (n < 1100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (init_done_o) break;
            if (a_ready_o || b_ready_o) early++;
        end
        check(name, n, 1024);
        check("ready_during_init", early, 0);
        check("a_ready_after_init", a_ready_o, 1);
    endtask

    initial begin
        logic        av, aw, bv;
        logic [10:0] aa, ba;

        tbl[0] = '{1, 0, 11'h000, 32'h0, 4'h0, 1, 11'h7FF, 1, 32'h0, 32'h0};
        tbl[1] = '{1, 1, 11'h405, 32'hDEADBEEF, 4'hF, 0, 11'h000, 1, 32'h0, 32'h0};
        tbl[2] = '{1, 0, 11'h405, 32'h0, 4'h0, 1, 11'h005, 1, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{1, 1, 11'h010, 32'h11223344, 4'hF, 0, 11'h000, 1, 32'h0, 32'h0};
        tbl[4] = '{1, 1, 11'h010, 32'hAABBCCDD, 4'b0101, 0, 11'h000, 1, 32'h0, 32'h0};
        tbl[5] = '{1, 0, 11'h010, 32'h0, 4'h0, 1, 11'h010, 1, 32'h11BB33DD, 32'h11BB33DD};
        tbl[6] = '{1, 1, 11'h020, 32'hCAFEF00D, 4'hF, 1, 11'h020, 0, 32'h0, 32'h0};
        tbl[7] = '{0, 0, 11'h000, 32'h0, 4'h0, 1, 11'h020, 1, 32'h0, 32'hCAFEF00D};
        tbl[8] = '{1, 1, 11'h020, 32'h12345678, 4'hF, 1, 11'h021, 1, 32'h0, 32'h0};
        tbl[9] = '{1, 0, 11'h020, 32'h0, 4'h0, 1, 11'h021, 1, 32'h12345678, 32'h0};

        @(negedge clk);
        do_reset(3);
        wait_init("init_cycles");

        for (int i = 0; i < 10; i++)
            step(tbl[i].av, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].am,
                 tbl[i].bv, tbl[i].ba, 1'b1, tbl[i].ea, tbl[i].eb, tbl[i].ebr);
        idle(LAT + 1);

        // Back-to-back reads on both ports, alternating banks
        for (int i = 0; i < 8; i++) begin
            aa = (i % 2 == 1) ? 11'h405 : 11'h010;
            ba = (i % 2 == 1) ? 11'h010 : 11'h405;
            step(1, 0, aa, '0, '0, 1, ba, 0, '0, '0, 1'b1);
        end
        idle(LAT + 1);

        // Random traffic over a small address set to provoke collisions
        for (int i = 0; i < 400; i++) begin
            av = ($urandom_range(0, 3) != 0);
            aw = $urandom_range(0, 1) == 1;
            aa = 11'(($urandom_range(0, 1) << 10) | $urandom_range(0, 7));
            bv = ($urandom_range(0, 3) != 0);
            ba = ($urandom_range(0, 2) == 0) ? aa
                 : 11'(($urandom_range(0, 1) << 10) | $urandom_range(0, 7));
            step(av, aw, aa, $urandom, 4'($urandom_range(0, 15)), bv, ba, 0, '0, '0, 1'b1);
        end
        idle(LAT + 1);

        // Reset in the middle of the zero-fill restarts the count
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        check("mid_init_done", init_done_o, 0);
        do_reset(2);
        wait_init("reinit_cycles");
        step(1, 0, 11'h405, '0, '0, 1, 11'h010, 0, '0, '0, 1'b1);
        step(1, 0, 11'h020, '0, '0, 1, 11'h407, 0, '0, '0, 1'b1);
        idle(LAT + 1);
        check("drain", 32'(qa.size() + qb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
